dmi_responder: RTL and testbench

- Debug-module-side responder for the DMI bus driven by the JTAG DTM (`jtag`). It is the other end of `dmi_req/addr/wdata/we` and `dmi_ack/op/rdata/rdata_valid`.
- Decodes each DMI request against a parameterised 32-bit register file and returns a status op after a fixed, configurable latency.
- Supports DTM hard reset and exposes sticky error and busy status.

---
 rtl/dmi_responder_if.sv | 33 +++
 rtl/dmi_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_dmi_responder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_responder_if.sv
// DMI request/response bus between the JTAG DTM and the debug module.
//
// Signals:
//   dmi_req         DTM -> DM  request level, held until the ack is seen
//   dmi_addr        DTM -> DM  request address
//   dmi_wdata       DTM -> DM  write data
//   dmi_we          DTM -> DM  1 = write, 0 = read
//   dmi_ack         DM -> DTM  single-cycle response strobe
//   dmi_op          DM -> DTM  response status (0 = success, 2 = failed)
//   dmi_rdata       DM -> DTM  read data, qualified by dmi_rdata_valid
//   dmi_rdata_valid DM -> DTM  high with ack for successful reads only
//
// Modports: master is the DTM side, slave is the debug-module side.
interface dmi_responder_if;
  logic        dmi_req;
  logic [31:0] dmi_addr;
  logic [31:0] dmi_wdata;
  logic        dmi_we;
  logic        dmi_ack;
  logic [1:0]  dmi_op;
  logic [31:0] dmi_rdata;
  logic        dmi_rdata_valid;

  modport master (
    output dmi_req, dmi_addr, dmi_wdata, dmi_we,
    input  dmi_ack, dmi_op, dmi_rdata, dmi_rdata_valid
  );

  modport slave (
    input  dmi_req, dmi_addr, dmi_wdata, dmi_we,
    output dmi_ack, dmi_op, dmi_rdata, dmi_rdata_valid
  );
endinterface

// File: rtl/dmi_responder.sv
// Debug-module-side DMI responder.
//
// Captures one request from the DTM at a time, decodes it against a small
// 32-bit register file and answers with a single-cycle ack a fixed number of
// cycles later. Register 0 is a read-only ID word; register 1 is exported
// live as dm_ctrl_o. Failed accesses set a sticky error flag.
//
// Ports:
//   jtag_tck_i       clock, everything runs on its rising edge
//   jtag_trstn_i     synchronous active-low reset
//   dmi              DMI bus, slave side (request in, response out)
//   dmi_hardreset_i  synchronous abort of the current request + register clear
//   dmi_busy_o       high whenever a request is being handled (FSM not idle)
//   dmi_err_o        sticky error flag
//   dm_ctrl_o        live value of register 1
//
// Parameters:
//   NUM_REGS   number of registers (2..64)
//   ADDR_BASE  DMI address of register 0
//   LATENCY    wait cycles between capture and ack (0..15)
//   ID_VALUE   read-only contents of register 0
module dmi_responder #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] ID_VALUE  = 32'h0000_0012
) (
  input  logic               jtag_tck_i,
  input  logic               jtag_trstn_i,
  dmi_responder_if.slave     dmi,
  input  logic               dmi_hardreset_i,
  output logic               dmi_busy_o,
  output logic               dmi_err_o,
  output logic [31:0]        dm_ctrl_o
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;

  // Register 0 is the constant ID word, so only indices 1.. need storage.
  logic [31:0] regs [1:NUM_REGS-1];

  logic        ack_q;
  logic [1:0]  op_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        busy_q;
  logic        err_q;

  // Decode results for the request being answered.
  logic [31:0] dec_addr;
  logic [31:0] dec_wdata;
  logic        dec_we;
  logic [32:0] diff;
  logic [31:0] idx;
  logic        in_range;
  logic        dec_fail;
  logic        do_write;
  logic [31:0] dec_rdata;
  logic        enter_resp;

  // With LATENCY = 0 the response is produced on the capture edge itself,
  // before addr_q/wdata_q/we_q hold the request, so in IDLE the decoder
  // looks straight at the bus. In every other state it uses the latched copy,
  // which makes later bus changes invisible.
  always_comb begin
    dec_addr  = addr_q;
    dec_wdata = wdata_q;
    dec_we    = we_q;
    if (state == IDLE) begin
      dec_addr  = dmi.dmi_addr;
      dec_wdata = dmi.dmi_wdata;
      dec_we    = dmi.dmi_we;
    end

    // 33-bit subtract so an address below the base shows up as a borrow
    // instead of wrapping into a large index.
    diff     = {1'b0, dec_addr} - {1'b0, ADDR_BASE};
    idx      = diff[31:0];
    in_range = !diff[32] && (idx < NUM_REGS);
    dec_fail = !in_range || (dec_we && (idx == 32'd0));
    do_write = in_range && dec_we && (idx != 32'd0);

    dec_rdata = 32'd0;
    if (in_range && !dec_we) begin
      if (idx == 32'd0) begin
        dec_rdata = ID_VALUE;
      end
      foreach (regs[i]) begin
        if (idx == 32'(i)) begin
          dec_rdata = regs[i];
        end
      end
    end
  end

  // The edge that moves the FSM into RESP is the one that registers the
  // response and performs any write. Hardreset suppresses it.
  always_comb begin
    enter_resp = 1'b0;
    if (!dmi_hardreset_i) begin
      if ((state == IDLE) && dmi.dmi_req && (LATENCY == 0)) begin
        enter_resp = 1'b1;
      end
      if ((state == WAIT) && (cnt <= 4'd1)) begin
        enter_resp = 1'b1;
      end
    end
  end

  // Main FSM with all outputs registered. Response outputs default to zero
  // every cycle so they are only non-zero during the single RESP cycle.
  // Hardreset wins over capture and write; it parks in HOLD while the DTM
  // still holds req so the aborted request is not captured again.
  always_ff @(posedge jtag_tck_i) begin
    if (!jtag_trstn_i) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      we_q          <= 1'b0;
      ack_q         <= 1'b0;
      op_q          <= 2'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      foreach (regs[i]) begin
        regs[i] <= 32'd0;
      end
    end else begin
      ack_q         <= 1'b0;
      op_q          <= 2'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;

      if (dmi_hardreset_i) begin
        err_q <= 1'b0;
        foreach (regs[i]) begin
          regs[i] <= 32'd0;
        end
        if (dmi.dmi_req) begin
          state  <= HOLD;
          busy_q <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (dmi.dmi_req) begin
              addr_q  <= dmi.dmi_addr;
              wdata_q <= dmi.dmi_wdata;
              we_q    <= dmi.dmi_we;
              cnt     <= LAT_LOAD;
              busy_q  <= 1'b1;
              state   <= (LATENCY == 0) ? RESP : WAIT;
            end
          end
          WAIT: begin
            if (cnt <= 4'd1) begin
              state <= RESP;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          RESP: begin
            state <= HOLD;
          end
          HOLD: begin
            // Four-phase handshake: only a low req lets a new one in.
            if (!dmi.dmi_req) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase

        if (enter_resp) begin
          ack_q         <= 1'b1;
          op_q          <= dec_fail ? 2'd2 : 2'd0;
          rdata_q       <= dec_rdata;
          rdata_valid_q <= in_range && !dec_we;
          if (dec_fail) begin
            err_q <= 1'b1;
          end
          if (do_write) begin
            foreach (regs[i]) begin
              if (idx == 32'(i)) begin
                regs[i] <= dec_wdata;
              end
            end
          end
        end
      end
    end
  end

  assign dmi.dmi_ack         = ack_q;
  assign dmi.dmi_op          = op_q;
  assign dmi.dmi_rdata       = rdata_q;
  assign dmi.dmi_rdata_valid = rdata_valid_q;
  assign dmi_busy_o          = busy_q;
  assign dmi_err_o           = err_q;
  assign dm_ctrl_o           = regs[1];

endmodule

// File: tb/tb_dmi_responder.sv
// Testbench for dmi_responder.
//
// Two instances share clock and reset: one with LATENCY = 2 at base 0 with
// 16 registers, one with LATENCY = 0 at base 0x40 with 8 registers. Each
// request pushes its predicted response onto a queue from a small register
// model; the response is popped and compared when the ack arrives.
module tb_dmi_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        trstn;
  logic        hr2;
  logic        hr0;
  logic        busy2;
  logic        err2;
  logic [31:0] ctrl2;
  logic        busy0;
  logic        err0;
  logic [31:0] ctrl0;

  dmi_responder_if if2 ();
  dmi_responder_if if0 ();

  dmi_responder #(
    .NUM_REGS (16),
    .ADDR_BASE(32'h0),
    .LATENCY  (2),
    .ID_VALUE (32'h0000_0012)
  ) dut (
    .jtag_tck_i     (clk),
    .jtag_trstn_i   (trstn),
    .dmi            (if2),
    .dmi_hardreset_i(hr2),
    .dmi_busy_o     (busy2),
    .dmi_err_o      (err2),
    .dm_ctrl_o      (ctrl2)
  );

  dmi_responder #(
    .NUM_REGS (8),
    .ADDR_BASE(32'h40),
    .LATENCY  (0),
    .ID_VALUE (32'hCAFE_0012)
  ) dut_lat0 (
    .jtag_tck_i     (clk),
    .jtag_trstn_i   (trstn),
    .dmi            (if0),
    .dmi_hardreset_i(hr0),
    .dmi_busy_o     (busy0),
    .dmi_err_o      (err0),
    .dm_ctrl_o      (ctrl0)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] rdata;
    logic        valid;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_regs [2][16];
  logic        model_err [2];
  int          n_checks = 0;
  int          n_fails  = 0;
  bit          use_l0   = 1'b0;

  // Monitored view of whichever instance is under test.
  logic        mon_ack;
  logic [1:0]  mon_op;
  logic [31:0] mon_rdata;
  logic        mon_valid;
  logic        mon_busy;
  logic        mon_err;
  logic [31:0] mon_ctrl;

  assign mon_ack   = use_l0 ? if0.dmi_ack         : if2.dmi_ack;
  assign mon_op    = use_l0 ? if0.dmi_op          : if2.dmi_op;
  assign mon_rdata = use_l0 ? if0.dmi_rdata       : if2.dmi_rdata;
  assign mon_valid = use_l0 ? if0.dmi_rdata_valid : if2.dmi_rdata_valid;
  assign mon_busy  = use_l0 ? busy0               : busy2;
  assign mon_err   = use_l0 ? err0                : err2;
  assign mon_ctrl  = use_l0 ? ctrl0               : ctrl2;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] a,
                       input logic [31:0] w, input logic we);
    if (use_l0) begin
      if0.dmi_req = req; if0.dmi_addr = a; if0.dmi_wdata = w; if0.dmi_we = we;
    end else begin
      if2.dmi_req = req; if2.dmi_addr = a; if2.dmi_wdata = w; if2.dmi_we = we;
    end
  endtask

  // Register model: predicts the response and updates its own state.
  task automatic predict(input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, output exp_t e);
    bit          s;
    logic [31:0] base;
    logic [31:0] nregs;
    logic [31:0] off;
    s     = use_l0;
    base  = use_l0 ? 32'h40 : 32'h0;
    nregs = use_l0 ? 32'd8 : 32'd16;
    e     = '0;
    off   = addr - base;
    if ((addr < base) || (off >= nregs)) begin
      e.op = 2'd2;
      model_err[s] = 1'b1;
    end else if (we) begin
      if (off == 32'd0) begin
        e.op = 2'd2;
        model_err[s] = 1'b1;
      end else begin
        model_regs[s][off[3:0]] = wdata;
      end
    end else begin
      e.valid = 1'b1;
      if (off == 32'd0) e.rdata = use_l0 ? 32'hCAFE_0012 : 32'h0000_0012;
      else              e.rdata = model_regs[s][off[3:0]];
    end
  endtask

  // One full four-phase transaction. Bus fields are scrambled right after
  // capture; hold_cycles keeps req high past the ack; wait_idle waits for
  // busy to drop after req is released.
  task automatic apply_stimulus(input logic [31:0] addr, input logic we,
                                input logic [31:0] wdata, input int hold_cycles,
                                input bit wait_idle);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   seen;
    int   extra_acks;
    int   busy_low;
    int   lat;
    bit   s;
    s = use_l0;
    predict(addr, we, wdata, e);
    sb_q.push_back(e);
    lat = use_l0 ? 1 : 3;

    @(posedge clk); #1;
    drive(1'b1, addr, wdata, we);
    @(posedge clk); #1;
    drive(1'b1, ~addr, ~wdata, ~we);

    seen = 1'b0;
    cyc  = 0;
    while (!seen && (cyc < 20)) begin
      @(negedge clk);
      cyc++;
      if (mon_ack) seen = 1'b1;
    end
    check_output("ack_seen", 32'(seen), 32'd1);
    check_output("ack_latency", 32'(cyc), 32'(lat));
    got = sb_q.pop_front();
    check_output("op", 32'(mon_op), 32'(got.op));
    check_output("rdata", mon_rdata, got.rdata);
    check_output("rdata_valid", 32'(mon_valid), 32'(got.valid));
    check_output("err", 32'(mon_err), 32'(model_err[s]));
    check_output("dm_ctrl", mon_ctrl, model_regs[s][1]);

    extra_acks = 0;
    busy_low   = 0;
    repeat (hold_cycles) begin
      @(negedge clk);
      if (mon_ack) extra_acks++;
      if (!mon_busy) busy_low++;
    end
    @(posedge clk); #1;
    drive(1'b0, ~addr, ~wdata, ~we);
    @(negedge clk);
    if (mon_ack) extra_acks++;
    check_output("no_second_ack", 32'(extra_acks), 32'd0);
    check_output("busy_while_req", 32'(busy_low), 32'd0);

    if (wait_idle) begin
      cyc = 0;
      while (mon_busy && (cyc < 10)) begin
        @(negedge clk);
        cyc++;
      end
      check_output("busy_release", 32'(mon_busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    int busy_low;
    int cyc;
    foreach (model_regs[s, k]) model_regs[s][k] = 32'd0;
    model_err[0] = 1'b0;
    model_err[1] = 1'b0;
    trstn = 1'b0;
    hr2   = 1'b0;
    hr0   = 1'b0;
    use_l0 = 1'b1; drive(1'b0, 32'd0, 32'd0, 1'b0);
    use_l0 = 1'b0; drive(1'b0, 32'd0, 32'd0, 1'b0);

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_ack", 32'(mon_ack), 32'd0);
    check_output("rst_op", 32'(mon_op), 32'd0);
    check_output("rst_rdata", mon_rdata, 32'd0);
    check_output("rst_valid", 32'(mon_valid), 32'd0);
    check_output("rst_busy", 32'(mon_busy), 32'd0);
    check_output("rst_err", 32'(mon_err), 32'd0);
    check_output("rst_ctrl", mon_ctrl, 32'd0);
    use_l0 = 1'b1;
    check_output("rst_l0_ack", 32'(mon_ack), 32'd0);
    check_output("rst_l0_busy", 32'(mon_busy), 32'd0);
    use_l0 = 1'b0;
    @(posedge clk); #1;
    trstn = 1'b1;

    $display("[TB] latency 2: write/read, errors, read-only ID");
    apply_stimulus(32'h0000_000a, 1'b1, 32'h0000_008c, 0, 1'b1);
    apply_stimulus(32'h0000_000a, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0012, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_000a, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0000, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0000, 1'b1, 32'h0000_0055, 0, 1'b1);
    apply_stimulus(32'h0000_0000, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_000f, 1'b1, 32'hDEAD_BEEF, 0, 1'b1);
    apply_stimulus(32'h0000_000f, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0010, 1'b1, 32'h1111_1111, 0, 1'b1);
    apply_stimulus(32'hFFFF_FFFF, 1'b0, 32'h0, 0, 1'b1);

    $display("[TB] latency 2: dm_ctrl write with req held past ack");
    apply_stimulus(32'h0000_0001, 1'b1, 32'hA5A5_0001, 6, 1'b1);

    $display("[TB] latency 2: hardreset during WAIT");
    @(posedge clk); #1;
    drive(1'b1, 32'h0000_0003, 32'h1234_5678, 1'b1);
    @(posedge clk); #1;
    hr2 = 1'b1;
    @(negedge clk);
    check_output("hr_busy_wait", 32'(mon_busy), 32'd1);
    @(posedge clk); #1;
    hr2 = 1'b0;
    for (int k = 1; k < 16; k++) model_regs[0][k] = 32'd0;
    model_err[0] = 1'b0;
    acks     = 0;
    busy_low = 0;
    repeat (5) begin
      @(negedge clk);
      if (mon_ack) acks++;
      if (!mon_busy) busy_low++;
    end
    check_output("hr_no_ack", 32'(acks), 32'd0);
    check_output("hr_hold_busy", 32'(busy_low), 32'd0);
    check_output("hr_err_clear", 32'(mon_err), 32'd0);
    check_output("hr_ctrl_clear", mon_ctrl, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0000_0003, 32'h1234_5678, 1'b1);
    cyc = 0;
    while (mon_busy && (cyc < 10)) begin
      @(negedge clk);
      cyc++;
    end
    check_output("hr_idle", 32'(mon_busy), 32'd0);
    apply_stimulus(32'h0000_0003, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_000a, 1'b0, 32'h0, 0, 1'b1);

    $display("[TB] latency 0: back-to-back and range");
    use_l0 = 1'b1;
    apply_stimulus(32'h0000_0042, 1'b1, 32'h0000_0077, 0, 1'b0);
    apply_stimulus(32'h0000_0042, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0040, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_003f, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0047, 1'b1, 32'h0000_0005, 0, 1'b1);
    apply_stimulus(32'h0000_0048, 1'b0, 32'h0, 0, 1'b1);
    apply_stimulus(32'h0000_0041, 1'b1, 32'h0000_0009, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
